load_store_unit: RTL and testbench

Memory-side initiator for the multicycle RISC-V core: accepts one load or store request from the control FSM, drives the word-addressed data memory's `A` / `Write_Data` / `Write_Enable` port, and returns a completion pulse.

- Handles byte, halfword and word accesses: little-endian lane selection, sign/zero extension, and read-modify-write for sub-word stores.
- Detects misaligned and illegal accesses without touching memory.
- Sits between the datapath (ALU result as address, rs2 as store data) and the data memory.

---
 rtl/load_store_unit.sv | 188 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit for the multicycle RISC-V core.
// Drives a word-addressed data memory; handles B/H/W with sub-word RMW stores.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_Read_Data,
    output logic [31:0] mem_A,
    output logic [31:0] mem_Write_Data,
    output logic        mem_Write_Enable,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic [2:0]  state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_data_q, store_data_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] load_data_q, load_data_d;
    logic        fault_q, fault_d;

    logic        req_illegal;
    logic        req_misaligned;
    logic        req_fault;
    logic        capture;

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [31:0] rd_shifted;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;
    logic [31:0] store_merge;

    // Fault classification uses the live request so IDLE can branch directly.
    always_comb begin
        req_illegal = 1'b1;
        unique case (funct3)
            F_B, F_H, F_W: req_illegal = 1'b0;
            F_BU, F_HU:    req_illegal = is_store;
            default:       req_illegal = 1'b1;
        endcase
    end

    always_comb begin
        req_misaligned = 1'b0;
        if (funct3[1:0] == 2'b01) begin
            req_misaligned = addr[0];
        end else if (funct3 == F_W) begin
            req_misaligned = (addr[1:0] != 2'b00);
        end
    end

    assign req_fault = req_illegal | req_misaligned;
    assign capture   = (state_q == S_IDLE) && start;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (req_fault) begin
                        state_d = S_DONE;
                    end else if (is_store && funct3 == F_W) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:   state_d = S_CAP;
            S_CAP:  state_d = is_store_q ? S_WR : S_DONE;
            S_WR:   state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        store_data_d = store_data_q;
        fault_d      = fault_q;
        if (capture) begin
            is_store_d   = is_store;
            funct3_d     = funct3;
            addr_d       = addr;
            store_data_d = store_data;
            fault_d      = req_fault;
        end
    end

    assign byte_sh    = {addr_q[1:0], 3'b000};
    assign half_sh    = {addr_q[1], 4'b0000};
    assign rd_shifted = mem_Read_Data >> byte_sh;
    assign rd_byte    = rd_shifted[7:0];
    assign rd_half    = addr_q[1] ? mem_Read_Data[31:16]
                                  : mem_Read_Data[15:0];

    always_comb begin
        load_ext = mem_Read_Data;
        unique case (funct3_q)
            F_B:     load_ext = {{24{rd_byte[7]}}, rd_byte};
            F_BU:    load_ext = {24'h0, rd_byte};
            F_H:     load_ext = {{16{rd_half[15]}}, rd_half};
            F_HU:    load_ext = {16'h0, rd_half};
            default: load_ext = mem_Read_Data;
        endcase
    end

    // Replace only the addressed lane of the word just read back.
    always_comb begin
        store_merge = mem_Read_Data;
        if (funct3_q[1:0] == 2'b00) begin
            store_merge = (mem_Read_Data & ~(32'h0000_00FF << byte_sh))
                        | ({24'h0, store_data_q[7:0]} << byte_sh);
        end else if (funct3_q[1:0] == 2'b01) begin
            store_merge = (mem_Read_Data & ~(32'h0000_FFFF << half_sh))
                        | ({16'h0, store_data_q[15:0]} << half_sh);
        end
    end

    always_comb begin
        merge_d     = merge_q;
        load_data_d = load_data_q;
        if (state_q == S_CAP) begin
            if (is_store_q) begin
                merge_d = store_merge;
            end else begin
                load_data_d = load_ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= 32'h0;
            store_data_q <= 32'h0;
            merge_q      <= 32'h0;
            load_data_q  <= 32'h0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            store_data_q <= store_data_d;
            merge_q      <= merge_d;
            load_data_q  <= load_data_d;
            fault_q      <= fault_d;
        end
    end

    assign mem_A            = {addr_q[31:2], 2'b00};
    assign mem_Write_Enable = (state_q == S_WR);
    assign mem_Write_Data   = (state_q != S_WR) ? 32'h0
                            : (funct3_q == F_W) ? store_data_q
                            : merge_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign fault     = done & fault_q;
    assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
// Models a 16-word synchronous-read data memory around the DUT.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] mem_Read_Data;
    logic [31:0] mem_A;
    logic [31:0] mem_Write_Data;
    logic        mem_Write_Enable;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        fault;

    int checks;
    int failures;
    int we_total;

    logic [31:0] mem [0:15];
    logic        bd_we;
    logic [3:0]  bd_idx;
    logic [31:0] bd_data;

    load_store_unit dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .is_store         (is_store),
        .funct3           (funct3),
        .addr             (addr),
        .store_data       (store_data),
        .mem_Read_Data    (mem_Read_Data),
        .mem_A            (mem_A),
        .mem_Write_Data   (mem_Write_Data),
        .mem_Write_Enable (mem_Write_Enable),
        .busy             (busy),
        .done             (done),
        .load_data        (load_data),
        .fault            (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_Read_Data <= mem[mem_A[5:2]];
        if (mem_Write_Enable) begin
            mem[mem_A[5:2]] <= mem_Write_Data;
            we_total <= we_total + 1;
        end else if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end
    end

    task automatic poke(input logic [3:0] idx, input logic [31:0] d);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_idx  = idx;
        bd_data = d;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    task automatic run_op(
        input  bit          st,
        input  logic [2:0]  f3,
        input  logic [31:0] a,
        input  logic [31:0] sd,
        output int          dcyc,
        output int          wecnt,
        output int          wecyc,
        output logic [31:0] wdat,
        output logic [31:0] waddr,
        output bit          flt
    );
        @(negedge clk);
        start      = 1'b1;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        @(posedge clk);
        #1 start = 1'b0;
        dcyc  = -1;
        wecnt = 0;
        wecyc = -1;
        wdat  = 32'h0;
        waddr = 32'h0;
        flt   = 1'b0;
        for (int c = 1; c <= 8 && dcyc < 0; c++) begin
            @(negedge clk);
            if (mem_Write_Enable) begin
                wecnt++;
                wecyc = c;
                wdat  = mem_Write_Data;
                waddr = mem_A;
            end
            if (done) begin
                dcyc = c;
                flt  = fault;
            end
        end
    endtask

    task automatic test_reset;
        int we0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || fault !== 1'b0
            || mem_Write_Enable !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got busy=%b done=%b fault=%b we=%b want 0",
                     busy, done, fault, mem_Write_Enable);
        end
        checks++;
        if (load_data !== 32'h0 || mem_A !== 32'h0
            || mem_Write_Data !== 32'h0 || dut.merge_q !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got ld=%h A=%h wd=%h mg=%h want 0",
                     load_data, mem_A, mem_Write_Data, dut.merge_q);
        end
        reset = 1'b0;
        poke(4'd1, 32'h1122_3344);
        we0 = we_total;
        @(negedge clk);
        start      = 1'b1;
        is_store   = 1'b1;
        funct3     = 3'b000;
        addr       = 32'h6;
        store_data = 32'h0000_00AB;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_rmw_busy got %b want 1", busy);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_Write_Enable !== 1'b0) begin
            failures++;
            $display("FAIL rst_abort_idle got busy=%b we=%b want 0 0",
                     busy, mem_Write_Enable);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (we_total !== we0 || mem[1] !== 32'h1122_3344) begin
            failures++;
            $display("FAIL rst_no_write got writes=%0d mem1=%h want 0 11223344",
                     we_total - we0, mem[1]);
        end
    endtask

    task automatic test_lw;
        int dc, wc, wy;
        logic [31:0] wd, wa;
        bit fl;
        poke(4'd4, 32'hDEAD_BEEF);
        run_op(1'b0, 3'b010, 32'h10, 32'h0, dc, wc, wy, wd, wa, fl);
        checks++;
        if (dc !== 3) begin
            failures++;
            $display("FAIL lw_done_cycle got %0d want 3", dc);
        end
        checks++;
        if (wc !== 0) begin
            failures++;
            $display("FAIL lw_no_write got %0d want 0", wc);
        end
        checks++;
        if (load_data !== 32'hDEAD_BEEF || fl !== 1'b0) begin
            failures++;
            $display("FAIL lw_data got %h fault=%b want deadbeef 0",
                     load_data, fl);
        end
    endtask

    task automatic test_subword_loads;
        logic [2:0]  f3v [4];
        logic [31:0] av  [4];
        logic [31:0] ev  [4];
        int dc, wc, wy;
        logic [31:0] wd, wa;
        bit fl;
        f3v = '{3'b000, 3'b100, 3'b001, 3'b101};
        av  = '{32'h4, 32'h5, 32'h6, 32'h6};
        ev  = '{32'hFFFF_FF80, 32'h0000_00F2, 32'hFFFF_8001, 32'h0000_8001};
        poke(4'd1, 32'h8001_F280);
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, f3v[i], av[i], 32'h0, dc, wc, wy, wd, wa, fl);
            checks++;
            if (load_data !== ev[i] || dc !== 3 || fl !== 1'b0) begin
                failures++;
                $display("FAIL subload_%0d got %h cyc=%0d f=%b want %h 3 0",
                         i, load_data, dc, fl, ev[i]);
            end
        end
    endtask

    task automatic test_stores;
        int dc, wc, wy;
        logic [31:0] wd, wa;
        bit fl;
        poke(4'd2, 32'h1122_3344);
        run_op(1'b1, 3'b000, 32'hA, 32'hFFFF_FFAB, dc, wc, wy, wd, wa, fl);
        checks++;
        if (wc !== 1 || wd !== 32'h11AB_3344 || wa !== 32'h8) begin
            failures++;
            $display("FAIL sb_write got n=%0d wd=%h a=%h want 1 11ab3344 8",
                     wc, wd, wa);
        end
        checks++;
        if (dc !== 4 || mem[2] !== 32'h11AB_3344) begin
            failures++;
            $display("FAIL sb_done got cyc=%0d mem=%h want 4 11ab3344",
                     dc, mem[2]);
        end
        run_op(1'b1, 3'b001, 32'h8, 32'h1234_CDEF, dc, wc, wy, wd, wa, fl);
        checks++;
        if (wc !== 1 || mem[2] !== 32'h11AB_CDEF || dc !== 4) begin
            failures++;
            $display("FAIL sh_merge got n=%0d mem=%h cyc=%0d want 1 11abcdef 4",
                     wc, mem[2], dc);
        end
        run_op(1'b1, 3'b010, 32'h8, 32'h0, dc, wc, wy, wd, wa, fl);
        checks++;
        if (wy !== 1 || dc !== 2 || wc !== 1 || mem[2] !== 32'h0) begin
            failures++;
            $display("FAIL sw_timing got wcyc=%0d dcyc=%0d n=%0d mem=%h want 1 2 1 0",
                     wy, dc, wc, mem[2]);
        end
    endtask

    task automatic test_faults;
        bit          stv [4];
        logic [2:0]  f3v [4];
        logic [31:0] av  [4];
        logic [31:0] snap [0:15];
        logic [31:0] ld0;
        int dc, wc, wy;
        logic [31:0] wd, wa;
        bit fl, same;
        stv = '{1'b0, 1'b1, 1'b1, 1'b0};
        f3v = '{3'b010, 3'b001, 3'b100, 3'b011};
        av  = '{32'h2, 32'h3, 32'h8, 32'h4};
        ld0 = load_data;
        for (int i = 0; i < 16; i++) snap[i] = mem[i];
        for (int i = 0; i < 4; i++) begin
            run_op(stv[i], f3v[i], av[i], 32'h5A5A_5A5A,
                   dc, wc, wy, wd, wa, fl);
            checks++;
            if (dc !== 1 || fl !== 1'b1 || wc !== 0) begin
                failures++;
                $display("FAIL fault_%0d got cyc=%0d f=%b n=%0d want 1 1 0",
                         i, dc, fl, wc);
            end
            same = 1'b1;
            for (int j = 0; j < 16; j++) if (mem[j] !== snap[j]) same = 1'b0;
            checks++;
            if (load_data !== ld0 || same !== 1'b1) begin
                failures++;
                $display("FAIL fault_state_%0d got ld=%h mem_same=%b want %h 1",
                         i, load_data, same, ld0);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] dmask;
        poke(4'd3, 32'hCAFE_F00D);
        poke(4'd5, 32'h1234_5678);
        dmask = 8'h0;
        @(negedge clk);
        start    = 1'b1;
        is_store = 1'b0;
        funct3   = 3'b010;
        addr     = 32'hC;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) addr = 32'h14;
            if (done) dmask[c] = 1'b1;
            if (c == 3) begin
                checks++;
                if (load_data !== 32'hCAFE_F00D) begin
                    failures++;
                    $display("FAIL b2b_first got %h want cafef00d", load_data);
                end
            end
            if (c == 4) begin
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_idle got busy=%b want 0", busy);
                end
            end
            if (c == 5) start = 1'b0;
            if (c == 7) begin
                checks++;
                if (load_data !== 32'h1234_5678 || fault !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_second got %h f=%b want 12345678 0",
                             load_data, fault);
                end
            end
        end
        checks++;
        if (dmask !== 8'b1000_1000) begin
            failures++;
            $display("FAIL b2b_done_mask got %b want 10001000", dmask);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        we_total   = 0;
        reset      = 1'b1;
        start      = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        store_data = 32'h0;
        bd_we      = 1'b0;
        bd_idx     = 4'd0;
        bd_data    = 32'h0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        test_reset;
        test_lw;
        test_subword_loads;
        test_stores;
        test_faults;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
